// File: rtl/hps_readout_handshake_ctrl_if.sv
// Producer and HPS PIO signal bundle for hps_readout_handshake_ctrl.
// The controller connects to the slave modport and the environment to the master modport.
interface hps_readout_handshake_ctrl_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  read_bit;
  logic                  enable;
  logic [DATA_W-1:0]     data_out;
  logic                  seq_out;
  logic                  pending;
  logic [DEPTH_LOG2:0]   fill_level;
  logic [15:0]           drop_count;
  logic                  timeout_flag;

  modport master (
    output in_valid, in_data, read_bit, enable,
    input  data_out, seq_out, pending, fill_level, drop_count, timeout_flag
  );

  modport slave (
    input  in_valid, in_data, read_bit, enable,
    output data_out, seq_out, pending, fill_level, drop_count, timeout_flag
  );
endinterface

// File: rtl/hps_readout_handshake_ctrl.sv
// FIFO-buffered toggle handshake that presents event words to the HPS over PIO lines.
// Optional ack watchdog enabled by defining HPS_HANDSHAKE_TIMEOUT_EN.
module hps_readout_handshake_ctrl #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH_LOG2     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input logic                       clk,
  input logic                       reset_n,
  hps_readout_handshake_ctrl_if.slave bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, LOAD, PRESENT} state_t;

  state_t                r_state;
  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2:0]   r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_rd_ptr;
  logic [DATA_W-1:0]     r_data;
  logic                  r_seq;
  logic                  r_pending;
  logic [15:0]           r_drop;

  logic [DEPTH_LOG2:0]   w_fill;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_ack;
  logic [DEPTH_LOG2:0]   w_wr_next;

  assign w_fill    = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_fill == '0);
  assign w_full    = (w_fill == (DEPTH_LOG2+1)'(DEPTH));
  assign w_pop     = (r_state == LOAD);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push    = bus.in_valid && (!w_full || w_pop);
  assign w_drop    = bus.in_valid && w_full && !w_pop;
  assign w_ack     = (r_state == PRESENT) && (bus.read_bit == r_seq);
  assign w_wr_next = r_wr_ptr + (DEPTH_LOG2+1)'(w_push);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= bus.in_data;
  end

`ifdef HPS_HANDSHAKE_TIMEOUT_EN
  logic [31:0] r_wdog;
  logic        r_timeout;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_data    <= '0;
      r_seq     <= 1'b0;
      r_pending <= 1'b0;
      r_drop    <= '0;
`ifdef HPS_HANDSHAKE_TIMEOUT_EN
      r_wdog    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_wr_ptr <= w_wr_next;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
      case (r_state)
        IDLE: begin
          if (!w_empty && bus.enable) r_state <= LOAD;
        end
        LOAD: begin
          r_data    <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
          r_seq     <= ~r_seq;
          r_pending <= 1'b1;
          r_state   <= PRESENT;
`ifdef HPS_HANDSHAKE_TIMEOUT_EN
          r_wdog    <= '0;
`endif
        end
        PRESENT: begin
          if (w_ack) begin
            r_pending <= 1'b0;
            r_state   <= (!w_empty && bus.enable) ? LOAD : IDLE;
          end
`ifdef HPS_HANDSHAKE_TIMEOUT_EN
          else if (r_wdog == 32'(TIMEOUT_CYCLES - 1)) begin
            // Flush includes any word pushed this cycle; seq stays so a late ack matches nothing.
            r_timeout <= 1'b1;
            r_rd_ptr  <= w_wr_next;
            r_pending <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.data_out   = r_data;
  assign bus.seq_out    = r_seq;
  assign bus.pending    = r_pending;
  assign bus.fill_level = w_fill;
  assign bus.drop_count = r_drop;

`ifdef HPS_HANDSHAKE_TIMEOUT_EN
  assign bus.timeout_flag = r_timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign bus.timeout_flag     = 1'b0;
`endif
endmodule

// File: tb/tb_hps_readout_handshake_ctrl.sv
// Directed self-checking bench for hps_readout_handshake_ctrl: vector table plus multi-cycle sequences.
module tb_hps_readout_handshake_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hps_readout_handshake_ctrl_if #(.DATA_W(32), .DEPTH_LOG2(4)) bus ();

  hps_readout_handshake_ctrl #(
    .DATA_W(32),
    .DEPTH_LOG2(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst_n;
    logic        v;
    logic [31:0] d;
    logic        rb;
    logic        en;
    logic [31:0] e_data;
    logic        e_seq;
    logic        e_pend;
    logic [4:0]  e_fill;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_data, input logic e_seq,
                         input logic e_pend, input logic [4:0] e_fill, input logic [15:0] e_drop,
                         input logic e_to);
    chk({tag, ".data_out"}, bus.data_out, e_data);
    chk({tag, ".seq_out"}, 32'(bus.seq_out), 32'(e_seq));
    chk({tag, ".pending"}, 32'(bus.pending), 32'(e_pend));
    chk({tag, ".fill_level"}, 32'(bus.fill_level), 32'(e_fill));
    chk({tag, ".drop_count"}, 32'(bus.drop_count), 32'(e_drop));
    chk({tag, ".timeout_flag"}, 32'(bus.timeout_flag), 32'(e_to));
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.read_bit = 1'b0;
    bus.enable   = 1'b1;
    step();
    reset_n = 1'b1;
  endtask

  task automatic push(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] abc [3];
    logic [31:0] exp_w;
    logic        e_seq;
    bit          ok;

    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.read_bit = 1'b0;
    bus.enable   = 1'b1;

    // Single-word transfer: push at row 2, presented two edges later, acked at row 6.
    vecs[0] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 5'd0, 16'd0};
    vecs[1] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 5'd0, 16'd0};
    vecs[2] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 5'd1, 16'd0};
    vecs[3] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 5'd1, 16'd0};
    vecs[4] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 5'd0, 16'd0};
    vecs[5] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 5'd0, 16'd0};
    vecs[6] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0, 16'd0};
    vecs[7] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0, 16'd0};

    for (int i = 0; i < 8; i++) begin
      reset_n      = vecs[i].rst_n;
      bus.in_valid = vecs[i].v;
      bus.in_data  = vecs[i].d;
      bus.read_bit = vecs[i].rb;
      bus.enable   = vecs[i].en;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_seq, vecs[i].e_pend,
              vecs[i].e_fill, vecs[i].e_drop, 1'b0);
    end

    // Three back-to-back words, each acked 5 cycles after it appears.
    do_reset();
    chk_all("abc_reset", 32'h0, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0);
    abc[0] = 32'hAAAA0001;
    abc[1] = 32'hBBBB0002;
    abc[2] = 32'hCCCC0003;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = abc[i];
      step();
    end
    bus.in_valid = 1'b0;
    chk("abc_fill_after_push", 32'(bus.fill_level), 32'd2);
    for (int k = 0; k < 3; k++) begin
      e_seq = (k % 2 == 0) ? 1'b1 : 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (bus.seq_out === e_seq && bus.pending === 1'b1) begin
          ok = 1'b1;
          break;
        end
        step();
      end
      chk($sformatf("abc%0d_presented", k), 32'(ok), 32'd1);
      chk($sformatf("abc%0d_data", k), bus.data_out, abc[k]);
      for (int c = 0; c < 5; c++) step();
      bus.read_bit = e_seq;
      step();
      chk($sformatf("abc%0d_ack_pending", k), 32'(bus.pending), 32'd0);
    end
    step();
    chk("abc_fill_end", 32'(bus.fill_level), 32'd0);

    // Overflow with no ack, then a full-FIFO pop+push, then drain in order.
    do_reset();
    for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
    chk_all("ovf16", 32'h100, 1'b1, 1'b1, 5'd15, 16'd0, 1'b0);
    push(32'h110);
    chk_all("ovf17", 32'h100, 1'b1, 1'b1, 5'd16, 16'd0, 1'b0);
    for (int i = 0; i < 4; i++) push(32'h120 + 32'(i));
    chk_all("ovf21", 32'h100, 1'b1, 1'b1, 5'd16, 16'd4, 1'b0);
    bus.read_bit = 1'b1;
    step();
    chk_all("ovf_ack_load", 32'h100, 1'b1, 1'b0, 5'd16, 16'd4, 1'b0);
    push(32'h200);
    chk_all("ovf_pop_push_full", 32'h101, 1'b0, 1'b1, 5'd16, 16'd4, 1'b0);
    e_seq = 1'b0;
    for (int j = 0; j < 16; j++) begin
      exp_w = (j < 15) ? 32'h102 + 32'(j) : 32'h200;
      bus.read_bit = e_seq;
      e_seq = ~e_seq;
      step();
      step();
      chk($sformatf("drain%0d_data", j), bus.data_out, exp_w);
      chk($sformatf("drain%0d_seq", j), 32'(bus.seq_out), 32'(e_seq));
    end
    chk("drain_fill", 32'(bus.fill_level), 32'd0);

    // enable=0 holds presentation while the FIFO keeps filling.
    do_reset();
    bus.enable = 1'b0;
    push(32'h300);
    push(32'h301);
    step();
    step();
    chk_all("en_hold", 32'h0, 1'b0, 1'b0, 5'd2, 16'd0, 1'b0);
    bus.enable = 1'b1;
    step();
    chk_all("en_load", 32'h0, 1'b0, 1'b0, 5'd2, 16'd0, 1'b0);
    step();
    chk_all("en_present", 32'h300, 1'b1, 1'b1, 5'd1, 16'd0, 1'b0);

    // Reset while a word is pending with a partly filled FIFO.
    do_reset();
    for (int i = 0; i < 6; i++) push(32'h500 + 32'(i));
    chk_all("mid_pre", 32'h500, 1'b1, 1'b1, 5'd5, 16'd0, 1'b0);
    reset_n = 1'b0;
    step();
    chk_all("mid_reset", 32'h0, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0);
    reset_n = 1'b1;
    bus.read_bit = 1'b1;
    step();
    step();
    step();
    chk_all("mid_late_ack", 32'h0, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0);
    bus.read_bit = 1'b0;

`ifdef HPS_HANDSHAKE_TIMEOUT_EN
    // Word enters PRESENT at the third edge; watchdog of 8 fires eight edges later.
    do_reset();
    push(32'h400);
    push(32'h401);
    step();
    chk_all("to_entry", 32'h400, 1'b1, 1'b1, 5'd1, 16'd0, 1'b0);
    for (int c = 0; c < 7; c++) step();
    chk_all("to_before", 32'h400, 1'b1, 1'b1, 5'd1, 16'd0, 1'b0);
    step();
    chk_all("to_fired", 32'h400, 1'b1, 1'b0, 5'd0, 16'd0, 1'b1);
    bus.read_bit = 1'b1;
    step();
    step();
    chk_all("to_late_ack", 32'h400, 1'b1, 1'b0, 5'd0, 16'd0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
